// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Two write-back producers (ALU, LSU) share the single RegisterFile write port.
// Each producer has its own small FIFO. A round-robin arbiter pops at most one
// FIFO head per cycle into a registered write stage. Writes to x0 complete the
// handshake but are never enqueued, so they can never reach the RegisterFile.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] AluAddr,
    input  logic [DATA_W-1:0] AluData,
    input  logic              LsuValid,
    output logic              LsuReady,
    input  logic [ADDR_W-1:0] LsuAddr,
    input  logic [DATA_W-1:0] LsuData,
    output logic              WriteEn,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              Busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    // Index 0 is the ALU queue, index 1 is the LSU queue.
    logic [ADDR_W-1:0] addr_mem_r [2][DEPTH];
    logic [DATA_W-1:0] data_mem_r [2][DEPTH];
    logic [PW-1:0]     rd_ptr_r   [2];
    logic [PW-1:0]     wr_ptr_r   [2];
    logic [CW-1:0]     count_r    [2];

    logic [ADDR_W-1:0] in_addr_s [2];
    logic [DATA_W-1:0] in_data_s [2];
    logic [1:0]        in_valid_s;
    logic [1:0]        ready_s;
    logic [1:0]        push_s;
    logic [1:0]        pop_s;
    logic [1:0]        not_empty_s;
    logic              grant_valid_s;
    logic              grant_sel_s;   // 0 = ALU, 1 = LSU
    logic              rr_last_r;     // requester granted most recently

    assign in_addr_s[0] = AluAddr;
    assign in_addr_s[1] = LsuAddr;
    assign in_data_s[0] = AluData;
    assign in_data_s[1] = LsuData;
    assign in_valid_s   = {LsuValid, AluValid};

    // Ready reflects only fullness; a pop in the same cycle does not reopen a full queue.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready_s[i]     = (count_r[i] != FULL_CNT);
            not_empty_s[i] = (count_r[i] != CNT_ZERO);
            // x0 writes are accepted but dropped here rather than queued.
            push_s[i]      = in_valid_s[i] & ready_s[i] &
                             (in_addr_s[i] != {ADDR_W{1'b0}});
        end
    end

    assign AluReady = ready_s[0];
    assign LsuReady = ready_s[1];

    // Round-robin choice between the two FIFO heads; a lone requester always wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
        case (not_empty_s)
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_sel_s   = ~rr_last_r;
            end
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_sel_s   = 1'b1;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_sel_s   = 1'b0;
            end
        endcase
    end

    assign pop_s[0] = grant_valid_s & ~grant_sel_s;
    assign pop_s[1] = grant_valid_s &  grant_sel_s;

    // Per-requester FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_r[i] <= PTR_ZERO;
                wr_ptr_r[i] <= PTR_ZERO;
                count_r[i]  <= CNT_ZERO;
                for (int j = 0; j < DEPTH; j++) begin
                    addr_mem_r[i][j] <= {ADDR_W{1'b0}};
                    data_mem_r[i][j] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    addr_mem_r[i][wr_ptr_r[i]] <= in_addr_s[i];
                    data_mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
                    wr_ptr_r[i]                <= wr_ptr_r[i] + PTR_ONE;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
                    2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Registered write stage feeding the RegisterFile, plus round-robin history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            WriteEn   <= 1'b0;
            WriteAddr <= {ADDR_W{1'b0}};
            WriteData <= {DATA_W{1'b0}};
            rr_last_r <= 1'b1;
        end else begin
            WriteEn <= grant_valid_s;
            if (grant_valid_s) begin
                WriteAddr <= addr_mem_r[grant_sel_s][rd_ptr_r[grant_sel_s]];
                WriteData <= data_mem_r[grant_sel_s][rd_ptr_r[grant_sel_s]];
                rr_last_r <= grant_sel_s;
            end else begin
                WriteAddr <= WriteAddr;
                WriteData <= WriteData;
                rr_last_r <= rr_last_r;
            end
        end
    end

    assign Busy = not_empty_s[0] | not_empty_s[1] | WriteEn;

endmodule
